// File: rtl/mem_access_ctrl.sv
// Data-memory access controller: checks alignment, issues one word-wide request,
// extracts and extends the load lane, and reports misalignment or ack timeout.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  read_write,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busywait,
    output logic [31:0] load_data,
    output logic        fault_misaligned,
    output logic        fault_timeout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_LDS   = 2'b10;
    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_ILL   = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic [31:0]      load_q, load_d;
    logic             fm_q, fm_d;
    logic             ft_q, ft_d;
    logic [1:0]       size_q, size_d;
    logic [1:0]       off_q, off_d;
    logic             sign_q, sign_d;

    logic [1:0]       op_c, size_c;
    logic             misaligned_c;
    logic [3:0]       be_c;
    logic [31:0]      wdata_c;
    logic [7:0]       byte_c;
    logic [15:0]      half_c;
    logic [31:0]      lane_c;

    assign op_c   = read_write[3:2];
    assign size_c = read_write[1:0];

    // Request decode from the live EX/MEM inputs; only consumed while idle.
    always_comb begin
        misaligned_c = 1'b0;
        be_c         = 4'b0000;
        wdata_c      = '0;
        case (size_c)
            SZ_BYTE: begin
                be_c    = 4'b0001 << addr[1:0];
                wdata_c = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                misaligned_c = addr[0];
                be_c         = addr[1] ? 4'b1100 : 4'b0011;
                wdata_c      = {2{store_data[15:0]}};
            end
            SZ_WORD: begin
                misaligned_c = (addr[1:0] != 2'b00);
                be_c         = 4'b1111;
                wdata_c      = store_data;
            end
            SZ_ILL:  misaligned_c = 1'b1;
            default: misaligned_c = 1'b1;
        endcase
        if (op_c != OP_STORE) begin
            wdata_c = '0;
        end
    end

    // Load lane selection by the byte offset captured at request time.
    assign byte_c = mem_rdata[{off_q, 3'b000} +: 8];
    assign half_c = mem_rdata[{off_q[1], 4'b0000} +: 16];

    always_comb begin
        case (size_q)
            SZ_BYTE: lane_c = {{24{sign_q & byte_c[7]}}, byte_c};
            SZ_HALF: lane_c = {{16{sign_q & half_c[15]}}, half_c};
            default: lane_c = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        load_d      = load_q;
        fm_d        = fm_q;
        ft_d        = ft_q;
        size_d      = size_q;
        off_d       = off_q;
        sign_d      = sign_q;
        case (state_q)
            S_IDLE: begin
                if (op_c != OP_NONE) begin
                    if (misaligned_c) begin
                        state_d = S_DONE;
                        fm_d    = 1'b1;
                        load_d  = '0;
                    end else begin
                        state_d     = S_REQ;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = (op_c == OP_STORE);
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_wdata_d = wdata_c;
                        mem_be_d    = be_c;
                        size_d      = size_c;
                        off_d       = addr[1:0];
                        sign_d      = (op_c == OP_LDS);
                    end
                end
            end
            S_REQ: begin
                // An ack on the final allowed cycle still wins over the timeout.
                if (mem_ack || cnt_q == CNT_LAST) begin
                    state_d     = S_DONE;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    mem_be_d    = '0;
                    if (mem_ack) begin
                        load_d = mem_we_q ? 32'h0 : lane_c;
                    end else begin
                        load_d = '0;
                        ft_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                load_d  = '0;
                fm_d    = 1'b0;
                ft_d    = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            load_q      <= '0;
            fm_q        <= 1'b0;
            ft_q        <= 1'b0;
            size_q      <= SZ_WORD;
            off_q       <= 2'b00;
            sign_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            load_q      <= load_d;
            fm_q        <= fm_d;
            ft_q        <= ft_d;
            size_q      <= size_d;
            off_q       <= off_d;
            sign_q      <= sign_d;
        end
    end

    // Stall is immediate on a new request so the pipeline never advances past it.
    assign busywait = !reset &&
                      ((state_q == S_IDLE && op_c != OP_NONE) || state_q == S_REQ);

    assign mem_req          = mem_req_q;
    assign mem_we           = mem_we_q;
    assign mem_addr         = mem_addr_q;
    assign mem_wdata        = mem_wdata_q;
    assign mem_be           = mem_be_q;
    assign load_data        = load_q;
    assign fault_misaligned = fm_q;
    assign fault_timeout    = ft_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: vector table through a scoreboard,
// plus hand sequences for back-to-back access, stray acks and mid-request reset.
module tb_mem_access_ctrl;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  read_write;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busywait;
    logic [31:0] load_data;
    logic        fault_misaligned;
    logic        fault_timeout;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    typedef struct {
        string       name;
        logic [3:0]  rw;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          ack_at;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic        e_we;
        logic [31:0] e_wdata;
        logic [31:0] e_load;
        logic        e_fm;
        logic        e_ft;
        int          e_busy;
        int          e_reqc;
    } vec_t;

    vec_t tbl[13];
    vec_t sb_q[$];

    mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .read_write       (read_write),
        .addr             (addr),
        .store_data       (store_data),
        .busywait         (busywait),
        .load_data        (load_data),
        .fault_misaligned (fault_misaligned),
        .fault_timeout    (fault_timeout),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_be           (mem_be),
        .mem_ack          (mem_ack),
        .mem_rdata        (mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [3:0] rw,
                                input logic [31:0] a, input logic [31:0] sd,
                                input logic [31:0] rd, input int ack,
                                input logic [31:0] ea, input logic [3:0] ebe,
                                input logic ewe, input logic [31:0] ewd,
                                input logic [31:0] el, input logic efm,
                                input logic eft, input int eb, input int er);
        vec_t v;
        v.name = n;    v.rw = rw;      v.addr = a;     v.sd = sd;
        v.rdata = rd;  v.ack_at = ack; v.e_addr = ea;  v.e_be = ebe;
        v.e_we = ewe;  v.e_wdata = ewd; v.e_load = el; v.e_fm = efm;
        v.e_ft = eft;  v.e_busy = eb;  v.e_reqc = er;
        return v;
    endfunction

    // Drives one access from IDLE and follows it to its DONE cycle.
    task automatic run_vec(input vec_t v, output int done_cyc, output int req_cyc);
        int          busy, reqc, bad_flag, bad_hold;
        bit          done;
        logic [31:0] o_addr, o_wdata;
        logic [3:0]  o_be;
        logic        o_we;
        vec_t        e;
        sb_q.push_back(v);
        @(negedge clk);
        read_write = v.rw; addr = v.addr; store_data = v.sd;
        mem_rdata = v.rdata; mem_ack = 1'b0;
        busy = 0; reqc = 0; bad_flag = 0; bad_hold = 0; done = 1'b0;
        done_cyc = -1; req_cyc = -1;
        o_addr = '0; o_wdata = '0; o_be = '0; o_we = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (c > 0 && !busywait) begin
                done = 1'b1;
                done_cyc = cyc_n;
                e = sb_q.pop_front();
                chk({e.name, " load_data"}, load_data, e.e_load);
                chk({e.name, " fault_misaligned"}, 32'(fault_misaligned), 32'(e.e_fm));
                chk({e.name, " fault_timeout"}, 32'(fault_timeout), 32'(e.e_ft));
                chk({e.name, " busy_cycles"}, 32'(busy), 32'(e.e_busy));
                chk({e.name, " req_cycles"}, 32'(reqc), 32'(e.e_reqc));
                chk({e.name, " req_in_done"}, 32'(mem_req), 32'h0);
                chk({e.name, " flags_outside_done"}, 32'(bad_flag), 32'h0);
                if (e.e_reqc > 0) begin
                    chk({e.name, " mem_addr"}, o_addr, e.e_addr);
                    chk({e.name, " mem_be"}, 32'(o_be), 32'(e.e_be));
                    chk({e.name, " mem_we"}, 32'(o_we), 32'(e.e_we));
                    chk({e.name, " mem_wdata"}, o_wdata, e.e_wdata);
                    chk({e.name, " req_hold"}, 32'(bad_hold), 32'h0);
                end
                read_write = 4'b0000;
                mem_ack = 1'b1;
            end else begin
                if (busywait) busy++;
                if (fault_misaligned || fault_timeout) bad_flag++;
                mem_ack = 1'b0;
                if (mem_req) begin
                    reqc++;
                    if (reqc == 1) begin
                        o_addr = mem_addr; o_wdata = mem_wdata;
                        o_be = mem_be; o_we = mem_we; req_cyc = cyc_n;
                    end else if (mem_addr !== o_addr || mem_wdata !== o_wdata ||
                                 mem_be !== o_be || mem_we !== o_we) begin
                        bad_hold++;
                    end
                    if (reqc == v.ack_at) mem_ack = 1'b1;
                    read_write = 4'($urandom);
                    addr = $urandom;
                    store_data = $urandom;
                end
                @(negedge clk);
            end
        end
        if (!done) begin
            e = sb_q.pop_front();
            chk({e.name, " done_reached"}, 32'h0, 32'h1);
            read_write = 4'b0000;
        end
    endtask

    initial begin
        int d1, r1, d2, r2;
        tbl[0]  = mk("lb_sext",    4'b1000, 32'h0000_1003, 32'h0,         32'h80FF_0000, 2,
                     32'h0000_1000, 4'b1000, 1'b0, 32'h0,         32'hFFFF_FF80, 1'b0, 1'b0, 3, 2);
        tbl[1]  = mk("sh_repl",    4'b0101, 32'h0000_2002, 32'h0000_ABCD, 32'h1234_5678, 1,
                     32'h0000_2000, 4'b1100, 1'b1, 32'hABCD_ABCD, 32'h0,         1'b0, 1'b0, 2, 1);
        tbl[2]  = mk("lw_misal",   4'b1010, 32'h0000_0001, 32'h0,         32'h0,         1,
                     32'h0,         4'b0000, 1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 1, 0);
        tbl[3]  = mk("lhu_timeout",4'b1101, 32'h0000_3000, 32'h0,         32'hDEAD_BEEF, 0,
                     32'h0000_3000, 4'b0011, 1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 5, 4);
        tbl[4]  = mk("lw_lastack", 4'b1010, 32'h0000_4004, 32'h0,         32'hCAFE_F00D, 4,
                     32'h0000_4004, 4'b1111, 1'b0, 32'h0,         32'hCAFE_F00D, 1'b0, 1'b0, 5, 4);
        tbl[5]  = mk("lh_hi",      4'b1001, 32'h0000_5002, 32'h0,         32'h8001_1234, 1,
                     32'h0000_5000, 4'b1100, 1'b0, 32'h0,         32'hFFFF_8001, 1'b0, 1'b0, 2, 1);
        tbl[6]  = mk("lh_lo",      4'b1001, 32'h0000_5000, 32'h0,         32'h8000_7FFE, 1,
                     32'h0000_5000, 4'b0011, 1'b0, 32'h0,         32'h0000_7FFE, 1'b0, 1'b0, 2, 1);
        tbl[7]  = mk("lbu_lane1",  4'b1100, 32'h0000_6001, 32'h0,         32'h0000_A500, 1,
                     32'h0000_6000, 4'b0010, 1'b0, 32'h0,         32'h0000_00A5, 1'b0, 1'b0, 2, 1);
        tbl[8]  = mk("sb_repl",    4'b0100, 32'h0000_7002, 32'hFFFF_FF3C, 32'h0,         3,
                     32'h0000_7000, 4'b0100, 1'b1, 32'h3C3C_3C3C, 32'h0,         1'b0, 1'b0, 4, 3);
        tbl[9]  = mk("sw_pass",    4'b0110, 32'h0000_8000, 32'h1122_3344, 32'h0,         1,
                     32'h0000_8000, 4'b1111, 1'b1, 32'h1122_3344, 32'h0,         1'b0, 1'b0, 2, 1);
        tbl[10] = mk("size_ill",   4'b1011, 32'h0000_9000, 32'h0,         32'h0,         1,
                     32'h0,         4'b0000, 1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 1, 0);
        tbl[11] = mk("sh_misal",   4'b0101, 32'h0000_A001, 32'h0000_1234, 32'h0,         1,
                     32'h0,         4'b0000, 1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 1, 0);
        tbl[12] = mk("lb_lane0",   4'b1000, 32'h0000_B000, 32'h0,         32'h1234_5680, 1,
                     32'h0000_B000, 4'b0001, 1'b0, 32'h0,         32'hFFFF_FF80, 1'b0, 1'b0, 2, 1);

        reset = 1'b1; read_write = 4'b1010; addr = '0; store_data = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst busywait", 32'(busywait), 32'h0);
        chk("rst mem_req", 32'(mem_req), 32'h0);
        chk("rst mem_we", 32'(mem_we), 32'h0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst mem_wdata", mem_wdata, 32'h0);
        chk("rst mem_be", 32'(mem_be), 32'h0);
        chk("rst load_data", load_data, 32'h0);
        chk("rst faults", 32'({fault_misaligned, fault_timeout}), 32'h0);
        read_write = 4'b0000;
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) run_vec(tbl[i], d1, r1);

        // Back-to-back load then store, each acked in its first request cycle.
        run_vec(mk("b2b_lw", 4'b1010, 32'h0000_C000, 32'h0, 32'h0BAD_F00D, 1,
                   32'h0000_C000, 4'b1111, 1'b0, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b0, 2, 1), d1, r1);
        run_vec(mk("b2b_sw", 4'b0110, 32'h0000_C004, 32'h55AA_55AA, 32'hFFFF_FFFF, 1,
                   32'h0000_C004, 4'b1111, 1'b1, 32'h55AA_55AA, 32'h0, 1'b0, 1'b0, 2, 1), d2, r2);
        chk("b2b second req gap", 32'(r2 - d1), 32'd2);

        // Idle cycles with stray acks must not start anything.
        @(negedge clk);
        read_write = 4'b0000; mem_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("idle ack busywait", 32'(busywait), 32'h0);
            chk("idle ack mem_req", 32'(mem_req), 32'h0);
        end
        mem_ack = 1'b0;

        // Reset asserted during the second request cycle.
        @(negedge clk);
        read_write = 4'b1010; addr = 32'h0000_D000;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("pre-reset mem_req", 32'(mem_req), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("async rst mem_req", 32'(mem_req), 32'h0);
        chk("async rst busywait", 32'(busywait), 32'h0);
        chk("async rst mem_addr", mem_addr, 32'h0);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("held rst busywait", 32'(busywait), 32'h0);
        end
        read_write = 4'b0000;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("post rst idle busywait", 32'(busywait), 32'h0);
            chk("post rst idle mem_req", 32'(mem_req), 32'h0);
            chk("post rst no done", 32'({fault_misaligned, fault_timeout}), 32'h0);
        end
        run_vec(tbl[0], d1, r1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, default 255, maximum REQ-state cycles to wait for mem_ack before abort (legal range 1..65535).
REQ-002 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: read_write  input  4  access code from EX/MEM register; [3:2] op (00 none, 01 store, 10 load signed, 11 load unsigned), [1:0] size (00 byte, 01 half, 10 word, 11 illegal).
REQ-005 SHALL have port: addr  input  32  byte address (EX/MEM alu_result).
REQ-006 SHALL have port: store_data  input  32  store operand (EX/MEM D_in).
REQ-007 SHALL have port: busywait  output  1  pipeline stall to EX/MEM and earlier stages.
REQ-008 SHALL have port: load_data  output  32  extended load result, valid in DONE.
REQ-009 SHALL have port: fault_misaligned  output  1  misaligned or illegal-size access, valid in DONE.
REQ-010 SHALL have port: fault_timeout  output  1  memory did not ack in time, valid in DONE.
REQ-011 SHALL have ports: mem_req output 1 request; mem_we output 1 write; mem_addr output 32 word address; mem_wdata output 32; mem_be output 4 byte enables.
REQ-012 SHALL have ports: mem_ack input 1 single-cycle completion; mem_rdata input 32 read word, valid with mem_ack.

Function
REQ-013 SHALL implement FSM states IDLE, REQ, DONE.
REQ-014 IDLE, op==00: SHALL stay IDLE, busywait=0.
REQ-015 IDLE, op!=00, aligned, legal size: SHALL assert busywait combinationally and go to REQ.
REQ-016 Alignment: half needs addr[0]==0, word needs addr[1:0]==00; size 11 is illegal; in IDLE a misaligned or illegal op SHALL assert busywait, issue no memory request, and go to DONE with fault_misaligned set.
REQ-017 REQ: SHALL hold mem_req=1, busywait=1, and registered mem_we/mem_addr/mem_wdata/mem_be, all captured on the IDLE->REQ edge.
REQ-018 mem_addr SHALL equal {addr[31:2],2'b00}; mem_we=1 only for store.
REQ-019 Stores: byte SHALL replicate store_data[7:0] to all 4 lanes with mem_be=0001<<addr[1:0]; half SHALL replicate [15:0] with mem_be=0011 or 1100 per addr[1]; word SHALL pass through with mem_be=1111.
REQ-020 Loads: mem_be SHALL be as for stores of the same size; mem_wdata SHALL be 0.
REQ-021 REQ with mem_ack=1: SHALL deassert mem_req next cycle, go to DONE, and register the extracted load lane (by addr[1:0]) sign-extended (op 10) or zero-extended (op 11); store returns load_data=0.
REQ-022 REQ: SHALL count cycles with a 16-bit counter cleared on entry; on reaching TIMEOUT_CYCLES without ack it SHALL drop mem_req, go to DONE with fault_timeout=1 and load_data=0.
REQ-023 A mem_ack arriving in the same cycle the count reaches TIMEOUT_CYCLES SHALL count as success (no fault).
REQ-024 DONE: SHALL drive busywait=0 for exactly one cycle, hold load_data and fault flags, then go to IDLE; flags SHALL be 0 in every other state.
REQ-025 mem_ack outside REQ SHALL be ignored.
REQ-026 Minimum latency: request seen in IDLE at cycle N, ack at N+1 -> DONE at N+2; busywait high for cycles N and N+1.
REQ-027 Inputs read_write/addr/store_data SHALL be sampled only in IDLE; changes during REQ/DONE SHALL have no effect.

Reset
REQ-028 reset SHALL force IDLE, counter 0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, load_data=0, both faults=0, immediately and asynchronously.
REQ-029 busywait SHALL be 0 while reset is high.
REQ-030 Reset during REQ SHALL abort the access with no DONE cycle; the first access after reset release SHALL start from IDLE.

Verification
REQ-031 LB, addr=0x1003, mem_rdata=0x80FF_0000 with ack after 2 REQ cycles -> mem_addr=0x1000, mem_be=0001<<3=1000, load_data=0xFFFF_FF80, busywait high 3 cycles.
REQ-032 SH, addr=0x2002, store_data=0x0000_ABCD -> mem_we=1, mem_wdata=0xABCD_ABCD, mem_be=1100, load_data=0 in DONE.
REQ-033 LW, addr=0x0001 -> mem_req never asserted, DONE with fault_misaligned=1, busywait high exactly 1 cycle.
REQ-034 TIMEOUT_CYCLES=4, LHU, no ack -> mem_req high 4 cycles then low, DONE with fault_timeout=1, load_data=0.
REQ-035 Back-to-back LW then SW, ack in first REQ cycle each -> DONE cycles of both seen, second mem_req asserted 2 cycles after the first DONE cycle, no stale data.
REQ-036 reset asserted in 2nd REQ cycle -> mem_req=0 and busywait=0 immediately; after release, op=00 keeps IDLE.
